// File: rtl/bus_resp_tracker.sv
// rtl/bus_resp_tracker.sv - in-order outstanding-request tracker with response routing and timeout
module bus_resp_tracker #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned NrHosts       = 1,
    parameter int unsigned NrDevices     = 1,
    parameter int unsigned Depth         = 4,
    parameter int unsigned TimeoutCycles = 16,
    localparam int unsigned NumBitsHostSel   = NrHosts > 1 ? $clog2(NrHosts) : 1,
    localparam int unsigned NumBitsDeviceSel = NrDevices > 1 ? $clog2(NrDevices) : 1,
    localparam int unsigned PtrW             = $clog2(Depth),
    localparam int unsigned CntW             = $clog2(Depth) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [NumBitsHostSel-1:0]   host_sel_i,
    input  logic [NumBitsDeviceSel-1:0] device_sel_i,
    input  logic                        device_rvalid_i,
    input  logic [DataWidth-1:0]        device_rdata_i,
    input  logic                        device_err_i,
    output logic [NrHosts-1:0]          host_rvalid_o,
    output logic [DataWidth-1:0]        host_rdata_o,
    output logic                        host_err_o,
    output logic [CntW-1:0]             outstanding_o,
    output logic                        full_o,
    output logic                        overflow_o,
    output logic                        timeout_o,
    output logic                        spurious_o
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWait   = 2'd1;
    localparam logic [1:0] StExpire = 2'd2;

    logic [NumBitsHostSel-1:0]   mem_host_q [Depth];
    logic                        mem_we_q   [Depth];
    logic [NumBitsDeviceSel-1:0] mem_dev_q  [Depth];

    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [1:0]           state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic [NrHosts-1:0]   host_rvalid_q, host_rvalid_d;
    logic [DataWidth-1:0] host_rdata_q, host_rdata_d;
    logic                 host_err_q, host_err_d;
    logic                 overflow_q, overflow_d;
    logic                 timeout_q, timeout_d;
    logic                 spurious_q, spurious_d;

    logic empty, full, device_pop, expire_pop, pop, push;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(Depth));
    assign device_pop = device_rvalid_i && !empty;
    // A real response landing in the EXPIRE cycle wins over the synthetic error.
    assign expire_pop = (state_q == StExpire) && !device_rvalid_i;
    assign pop        = device_pop || expire_pop;
    assign push       = req_i && (!full || pop);

    // The target device is recorded with each entry; routing only needs the host.
    logic unused_head_dev;
    assign unused_head_dev = ^mem_dev_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d       = count_q + CntW'(push) - CntW'(pop);
        host_rvalid_d = '0;
        host_rdata_d  = '0;
        host_err_d    = 1'b0;
        if (pop) begin
            host_rvalid_d = NrHosts'(1) << mem_host_q[rd_ptr_q];
            if (expire_pop) begin
                host_err_d = 1'b1;
            end else begin
                host_rdata_d = mem_we_q[rd_ptr_q] ? '0 : device_rdata_i;
                host_err_d   = device_err_i;
            end
        end
        overflow_d = overflow_q | (req_i && full && !pop);
        spurious_d = spurious_q | (device_rvalid_i && empty);
        timeout_d  = timeout_q | expire_pop;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (push) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (pop) begin
                    timer_d = '0;
                    if (count_d == '0) state_d = StIdle;
                end else if (timer_q == 8'(TimeoutCycles - 1)) begin
                    state_d = StExpire;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StExpire: begin
                timer_d = '0;
                state_d = (count_d == '0) ? StIdle : StWait;
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_host_q[wr_ptr_q] <= host_sel_i;
            mem_we_q[wr_ptr_q]   <= we_i;
            mem_dev_q[wr_ptr_q]  <= device_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= StIdle;
            timer_q       <= '0;
            host_rvalid_q <= '0;
            host_rdata_q  <= '0;
            host_err_q    <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            host_err_q    <= host_err_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            spurious_q    <= spurious_d;
        end
    end

    assign host_rvalid_o = host_rvalid_q;
    assign host_rdata_o  = host_rdata_q;
    assign host_err_o    = host_err_q;
    assign outstanding_o = count_q;
    assign full_o        = full;
    assign overflow_o    = overflow_q;
    assign timeout_o     = timeout_q;
    assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_bus_resp_tracker.sv
// tb/tb_bus_resp_tracker.sv - directed vector bench for bus_resp_tracker
module tb_bus_resp_tracker;

    typedef struct {
        logic        rst;
        logic        req;
        logic        we;
        logic [1:0]  host;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  e_hrv;
        logic [31:0] e_rdata;
        logic        e_err;
        logic [2:0]  e_out;
        logic [3:0]  e_flags;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  host_sel_i;
    logic [0:0]  device_sel_i;
    logic        device_rvalid_i;
    logic [31:0] device_rdata_i;
    logic        device_err_i;
    logic [3:0]  host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        host_err_o;
    logic [2:0]  outstanding_o;
    logic        full_o, overflow_o, timeout_o, spurious_o;
    logic [3:0]  flags;

    int n_total = 0;
    int n_bad   = 0;
    int n_lat;
    vec_t vecs[18];

    assign flags = {full_o, overflow_o, timeout_o, spurious_o};

    bus_resp_tracker #(
        .DataWidth(32), .NrHosts(4), .NrDevices(2), .Depth(4), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .host_sel_i(host_sel_i), .device_sel_i(device_sel_i),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
        .device_err_i(device_err_i), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .outstanding_o(outstanding_o), .full_o(full_o), .overflow_o(overflow_o),
        .timeout_o(timeout_o), .spurious_o(spurious_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic req, input logic we,
                                input logic [1:0] host, input logic rv,
                                input logic [31:0] rdata, input logic err,
                                input logic [3:0] e_hrv, input logic [31:0] e_rdata,
                                input logic e_err, input logic [2:0] e_out,
                                input logic [3:0] e_flags);
        vec_t v;
        v.rst = rst; v.req = req; v.we = we; v.host = host; v.rv = rv;
        v.rdata = rdata; v.err = err; v.e_hrv = e_hrv; v.e_rdata = e_rdata;
        v.e_err = e_err; v.e_out = e_out; v.e_flags = e_flags;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; host_sel_i = '0; device_sel_i = '0;
        device_rvalid_i = 1'b0; device_rdata_i = '0; device_err_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cycle();
            if (host_rvalid_o != '0) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        //                rst req we host rv rdata          err  e_hrv   e_rdata        e_err out flags{full,ovf,to,sp}
        vecs[0]  = mk(1, 0, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd0, 4'b0000);
        vecs[1]  = mk(0, 1, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd1, 4'b0000);
        vecs[2]  = mk(0, 0, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd1, 4'b0000);
        vecs[3]  = mk(0, 0, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd1, 4'b0000);
        vecs[4]  = mk(0, 0, 0, 2'd0, 1, 32'hCAFE_0001,  0, 4'b0001, 32'hCAFE_0001,  0, 3'd0, 4'b0000);
        vecs[5]  = mk(0, 0, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd0, 4'b0000);
        vecs[6]  = mk(0, 0, 0, 2'd0, 1, 32'h0000_1234,  1, 4'b0000, 32'h0,          0, 3'd0, 4'b0001);
        vecs[7]  = mk(0, 1, 0, 2'd1, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd1, 4'b0001);
        vecs[8]  = mk(0, 1, 1, 2'd2, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd2, 4'b0001);
        vecs[9]  = mk(0, 1, 0, 2'd3, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd3, 4'b0001);
        vecs[10] = mk(0, 1, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd4, 4'b1001);
        vecs[11] = mk(0, 1, 0, 2'd1, 1, 32'h0000_00A0,  0, 4'b0010, 32'h0000_00A0,  0, 3'd4, 4'b1001);
        vecs[12] = mk(0, 1, 0, 2'd2, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd4, 4'b1101);
        vecs[13] = mk(0, 0, 0, 2'd0, 1, 32'h0000_00B1,  1, 4'b0100, 32'h0,          1, 3'd3, 4'b0101);
        vecs[14] = mk(0, 0, 0, 2'd0, 1, 32'h0000_00C2,  0, 4'b1000, 32'h0000_00C2,  0, 3'd2, 4'b0101);
        vecs[15] = mk(0, 0, 0, 2'd0, 1, 32'h0000_00D3,  0, 4'b0001, 32'h0000_00D3,  0, 3'd1, 4'b0101);
        vecs[16] = mk(0, 0, 0, 2'd0, 1, 32'h0000_00E4,  0, 4'b0010, 32'h0000_00E4,  0, 3'd0, 4'b0101);
        vecs[17] = mk(0, 0, 0, 2'd0, 0, 32'h0,          0, 4'b0000, 32'h0,          0, 3'd0, 4'b0101);

        idle_in();
        for (int i = 0; i < 18; i++) begin
            rst_i = vecs[i].rst; req_i = vecs[i].req; we_i = vecs[i].we;
            host_sel_i = vecs[i].host; device_sel_i = vecs[i].host[0];
            device_rvalid_i = vecs[i].rv; device_rdata_i = vecs[i].rdata;
            device_err_i = vecs[i].err;
            cycle();
            check($sformatf("row%0d_hrv", i),   32'(host_rvalid_o), 32'(vecs[i].e_hrv));
            check($sformatf("row%0d_rdata", i), host_rdata_o,       vecs[i].e_rdata);
            check($sformatf("row%0d_err", i),   32'(host_err_o),    32'(vecs[i].e_err));
            check($sformatf("row%0d_out", i),   32'(outstanding_o), 32'(vecs[i].e_out));
            check($sformatf("row%0d_flags", i), 32'(flags),         32'(vecs[i].e_flags));
        end

        // Two queued requests time out back to back; reset must clear sticky flags.
        do_reset();
        check("to_rst_flags", 32'(flags), 32'h0);
        req_i = 1'b1; host_sel_i = 2'd2;
        cycle();
        host_sel_i = 2'd3;
        cycle();
        idle_in();
        check("to_out2", 32'(outstanding_o), 32'd2);
        wait_resp(40, n_lat);
        check("to1_latency", 32'(n_lat), 32'd16);
        check("to1_hrv", 32'(host_rvalid_o), 32'b0100);
        check("to1_rdata", host_rdata_o, 32'h0);
        check("to1_err", 32'(host_err_o), 32'd1);
        check("to1_flags", 32'(flags), 32'b0010);
        check("to1_out", 32'(outstanding_o), 32'd1);
        wait_resp(40, n_lat);
        check("to2_latency", 32'(n_lat), 32'd17);
        check("to2_hrv", 32'(host_rvalid_o), 32'b1000);
        check("to2_err", 32'(host_err_o), 32'd1);
        check("to2_out", 32'(outstanding_o), 32'd0);
        cycle();
        check("to2_after_hrv", 32'(host_rvalid_o), 32'h0);

        // Device response arrives exactly in the EXPIRE cycle.
        do_reset();
        req_i = 1'b1; host_sel_i = 2'd1;
        cycle();
        idle_in();
        repeat (16) cycle();
        check("exp_early_hrv", 32'(host_rvalid_o), 32'h0);
        device_rvalid_i = 1'b1; device_rdata_i = 32'h0000_0055;
        cycle();
        idle_in();
        check("exp_hrv", 32'(host_rvalid_o), 32'b0010);
        check("exp_rdata", host_rdata_o, 32'h0000_0055);
        check("exp_err", 32'(host_err_o), 32'd0);
        check("exp_flags", 32'(flags), 32'b0000);
        check("exp_out", 32'(outstanding_o), 32'd0);
        cycle();
        check("exp_once_hrv", 32'(host_rvalid_o), 32'h0);
        check("exp_once_flags", 32'(flags), 32'b0000);

        // Reset with three requests outstanding, then a stale device response.
        do_reset();
        for (int h = 0; h < 3; h++) begin
            req_i = 1'b1; host_sel_i = 2'(h);
            cycle();
        end
        idle_in();
        check("rm_out3", 32'(outstanding_o), 32'd3);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        check("rm_rst_out", 32'(outstanding_o), 32'd0);
        check("rm_rst_hrv", 32'(host_rvalid_o), 32'h0);
        check("rm_rst_flags", 32'(flags), 32'h0);
        device_rvalid_i = 1'b1; device_rdata_i = 32'h0000_0077;
        cycle();
        idle_in();
        check("rm_stale_hrv", 32'(host_rvalid_o), 32'h0);
        check("rm_stale_rdata", host_rdata_o, 32'h0);
        check("rm_stale_flags", 32'(flags), 32'b0001);
        check("rm_stale_out", 32'(outstanding_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
